// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------------------------
// mem_access_ctrl
//
// Initiator-side controller between the load/store stage and the byte-addressed, big-endian
// memory. It takes one request at a time, screens it for size/alignment/range errors and then
// drives the memory's posedge-read / negedge-write protocol. Load data comes back sign- or
// zero-extended on a valid/ready response channel.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_write            1 = store, 0 = load
//   req_addr             byte address
//   req_wdata            store data, right-justified
//   req_size             00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned         zero-extend loads when set
//   resp_valid/ready     response handshake
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_error           misaligned, out-of-range or illegal size
//   mem_address          memory address
//   mem_data_in          memory write data
//   mem_write            memory write strobe (high for exactly one clock)
//   mem_access_size      memory access size
//   mem_data_out         memory read data (sub-word results right-justified)
// ---------------------------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8002_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE  = 32'h0010_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [ADDR_W-1:0] mem_data_in,
    output logic              mem_write,
    output logic [1:0]        mem_access_size,
    input  logic [ADDR_W-1:0] mem_data_out
);

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdCap,
        StWr,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_error_q, resp_error_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [ADDR_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              mem_write_q, mem_write_d;
    logic [1:0]        mem_access_size_q, mem_access_size_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_unsigned_q, ld_unsigned_d;

    // -----------------------------------------------------------------------------------------
    // Request screening. Range arithmetic is one bit wider than the address so that an access
    // running past the top of the address space cannot wrap back into the window.
    // -----------------------------------------------------------------------------------------
    logic [2:0]      nbytes;
    logic [ADDR_W:0] offset;
    logic [ADDR_W:0] end_ext;
    logic            below_base;
    logic            out_range;
    logic            misaligned;
    logic            illegal_size;
    logic            req_err;
    logic            accept;

    always_comb begin
        case (req_size)
            SzByte:  nbytes = 3'd1;
            SzHalf:  nbytes = 3'd2;
            SzWord:  nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    always_comb begin
        offset       = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        end_ext      = offset + {{(ADDR_W-2){1'b0}}, nbytes};
        below_base   = req_addr < BASE_ADDR;
        out_range    = below_base || (end_ext > {1'b0, MEM_SIZE});
        misaligned   = ((req_size == SzHalf) && req_addr[0]) ||
                       ((req_size == SzWord) && (req_addr[1:0] != 2'b00));
        illegal_size = req_size == 2'b11;
        req_err      = illegal_size || misaligned || out_range;
        accept       = req_valid && req_ready_q;
    end

    // -----------------------------------------------------------------------------------------
    // Load extension. The memory leaves stale upper bits on sub-word reads, so only the low
    // byte/halfword is ever looked at.
    // -----------------------------------------------------------------------------------------
    logic [ADDR_W-1:0] ld_ext;
    logic              ld_sign;

    always_comb begin
        ld_sign = 1'b0;
        ld_ext  = mem_data_out;
        case (ld_size_q)
            SzByte: begin
                ld_sign = ~ld_unsigned_q & mem_data_out[7];
                ld_ext  = {{(ADDR_W-8){ld_sign}}, mem_data_out[7:0]};
            end
            SzHalf: begin
                ld_sign = ~ld_unsigned_q & mem_data_out[15];
                ld_ext  = {{(ADDR_W-16){ld_sign}}, mem_data_out[15:0]};
            end
            default: ld_ext = mem_data_out;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        resp_valid_d      = resp_valid_q;
        resp_rdata_d      = resp_rdata_q;
        resp_error_d      = resp_error_q;
        mem_address_d     = mem_address_q;
        mem_data_in_d     = mem_data_in_q;
        mem_access_size_d = mem_access_size_q;
        mem_write_d       = 1'b0;
        ld_size_d         = ld_size_q;
        ld_unsigned_d     = ld_unsigned_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        // Rejected requests never touch the memory interface.
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        mem_address_d     = req_addr;
                        mem_access_size_d = req_size;
                        if (req_write) begin
                            mem_data_in_d = req_wdata;
                            mem_write_d   = 1'b1;
                            state_d       = StWr;
                        end else begin
                            ld_size_d     = req_size;
                            ld_unsigned_d = req_unsigned;
                            state_d       = StRdIssue;
                        end
                    end
                end
            end
            // Memory samples the address on this edge; data is valid on the next one.
            StRdIssue: state_d = StRdCap;
            StRdCap: begin
                resp_rdata_d = ld_ext;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                state_d      = StResp;
            end
            // The write committed on the negedge inside this state.
            StWr: begin
                resp_rdata_d = '0;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                state_d      = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_error_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = state_d == StIdle;
    end

    // -----------------------------------------------------------------------------------------
    // State register. req_ready is held low during reset and rises on the first edge after
    // release.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            req_ready_q       <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_rdata_q      <= '0;
            resp_error_q      <= 1'b0;
            mem_address_q     <= BASE_ADDR;
            mem_data_in_q     <= '0;
            mem_write_q       <= 1'b0;
            mem_access_size_q <= SzWord;
            ld_size_q         <= SzWord;
            ld_unsigned_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_ready_q       <= req_ready_d;
            resp_valid_q      <= resp_valid_d;
            resp_rdata_q      <= resp_rdata_d;
            resp_error_q      <= resp_error_d;
            mem_address_q     <= mem_address_d;
            mem_data_in_q     <= mem_data_in_d;
            mem_write_q       <= mem_write_d;
            mem_access_size_q <= mem_access_size_d;
            ld_size_q         <= ld_size_d;
            ld_unsigned_q     <= ld_unsigned_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_error      = resp_error_q;
    assign mem_address     = mem_address_q;
    assign mem_data_in     = mem_data_in_q;
    assign mem_write       = mem_write_q;
    assign mem_access_size = mem_access_size_q;

endmodule
